// File: rtl/jtag_scan_chain.sv
// JTAG instruction and data register stage that sits behind the TAP state machine.
// Holds the IR plus the IDCODE, BYPASS and USER data registers, and drives a registered TDO.
module jtag_scan_chain #(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h000FAF01,
  parameter int          USER_WIDTH = 8
) (
  input  logic                  tck,
  input  logic                  trst,
  input  logic                  tdi,
  input  logic                  test_logic_reset,
  input  logic                  capture_ir,
  input  logic                  shift_ir,
  input  logic                  update_ir,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  input  logic [USER_WIDTH-1:0] user_capture_in,
  output logic                  tdo,
  output logic [IR_WIDTH-1:0]   ir_value,
  output logic [USER_WIDTH-1:0] user_q,
  output logic                  abort_pulse
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(4'b1110);
  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = IR_WIDTH'(4'b1111);
  localparam logic [IR_WIDTH-1:0] IR_ABORT   = IR_WIDTH'(4'b1000);
  localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(4'b0010);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER,
    DR_ABORT
  } dr_sel_t;

  dr_sel_t               dr_sel;
  logic [IR_WIDTH-1:0]   ir_shift;
  logic [31:0]           idcode_shift;
  logic                  bypass_bit;
  logic [USER_WIDTH-1:0] user_shift;
  logic [USER_WIDTH-1:0] user_shift_next;
  logic                  dr_lsb;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    dr_sel = DR_BYPASS;
    case (ir_value)
      IR_IDCODE: dr_sel = DR_IDCODE;
      IR_BYPASS: dr_sel = DR_BYPASS;
      IR_ABORT:  dr_sel = DR_ABORT;
      IR_USER:   dr_sel = DR_USER;
      default:   dr_sel = DR_BYPASS;
    endcase
  end

  // ABORT and unrecognised codes scan through the bypass bit.
  always_comb begin
    dr_lsb = bypass_bit;
    case (dr_sel)
      DR_IDCODE: dr_lsb = idcode_shift[0];
      DR_USER:   dr_lsb = user_shift[0];
      default:   dr_lsb = bypass_bit;
    endcase
  end

  // Written as shift-and-or so a 1-bit USER register needs no empty slice.
  assign user_shift_next = (user_shift >> 1) | (USER_WIDTH'(tdi) << (USER_WIDTH - 1));

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      tdo          <= 1'b0;
      ir_value     <= IR_IDCODE;
      ir_shift     <= '0;
      user_q       <= '0;
      abort_pulse  <= 1'b0;
      idcode_shift <= IDCODE_VAL;
      bypass_bit   <= 1'b0;
      user_shift   <= '0;
    end else begin
      tdo         <= 1'b0;
      abort_pulse <= 1'b0;
      if (test_logic_reset) begin
        ir_value <= IR_IDCODE;
        ir_shift <= '0;
      end else if (capture_ir) begin
        ir_shift <= IR_CAPTURE;
      end else if (capture_dr) begin
        case (dr_sel)
          DR_IDCODE: idcode_shift <= IDCODE_VAL;
          DR_USER:   user_shift   <= user_capture_in;
          DR_BYPASS: bypass_bit   <= 1'b0;
          default:   ;
        endcase
      end else if (shift_ir) begin
        tdo      <= ir_shift[0];
        ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
      end else if (shift_dr) begin
        tdo <= dr_lsb;
        case (dr_sel)
          DR_IDCODE: idcode_shift <= {tdi, idcode_shift[31:1]};
          DR_USER:   user_shift   <= user_shift_next;
          default:   bypass_bit   <= tdi;
        endcase
      end else if (update_ir) begin
        ir_value    <= ir_shift;
        abort_pulse <= (ir_shift == IR_ABORT);
      end else if (update_dr) begin
        if (dr_sel == DR_USER) user_q <= user_shift;
      end
    end
  end

endmodule

// File: tb/tb_jtag_scan_chain.sv
// Self-checking bench for jtag_scan_chain: vector table driven through a scoreboard queue,
// plus hand-written IDCODE wrap-through and asynchronous-reset sequences.
module tb_jtag_scan_chain;

  localparam logic [31:0] IDC = 32'h000FAF01;
  localparam logic [31:0] PAT = 32'h000000B7;
  localparam logic [7:0]  UCAP = 8'hA5;
  localparam logic [7:0]  USCAN = 8'h3C;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_TLR  = 7'b1000000;
  localparam logic [6:0] S_CIR  = 7'b0100000;
  localparam logic [6:0] S_SIR  = 7'b0010000;
  localparam logic [6:0] S_UIR  = 7'b0001000;
  localparam logic [6:0] S_CDR  = 7'b0000100;
  localparam logic [6:0] S_SDR  = 7'b0000010;
  localparam logic [6:0] S_UDR  = 7'b0000001;

  typedef struct {
    logic [6:0] strb;
    logic       tdi;
    logic [7:0] uin;
    logic       e_tdo;
    logic [3:0] e_ir;
    logic [7:0] e_user;
    logic       e_abort;
  } vec_t;

  logic       tck = 1'b0;
  logic       trst;
  logic       tdi;
  logic       test_logic_reset, capture_ir, shift_ir, update_ir;
  logic       capture_dr, shift_dr, update_dr;
  logic [7:0] user_capture_in;
  logic       tdo;
  logic [3:0] ir_value;
  logic [7:0] user_q;
  logic       abort_pulse;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  jtag_scan_chain #(
    .IR_WIDTH  (4),
    .IDCODE_VAL(IDC),
    .USER_WIDTH(8)
  ) dut (
    .tck             (tck),
    .trst            (trst),
    .tdi             (tdi),
    .test_logic_reset(test_logic_reset),
    .capture_ir      (capture_ir),
    .shift_ir        (shift_ir),
    .update_ir       (update_ir),
    .capture_dr      (capture_dr),
    .shift_dr        (shift_dr),
    .update_dr       (update_dr),
    .user_capture_in (user_capture_in),
    .tdo             (tdo),
    .ir_value        (ir_value),
    .user_q          (user_q),
    .abort_pulse     (abort_pulse)
  );

  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] s, input logic t, input logic [7:0] u,
                              input logic et, input logic [3:0] ei, input logic [7:0] eu,
                              input logic ea);
    vec_t v;
    v.strb = s; v.tdi = t; v.uin = u;
    v.e_tdo = et; v.e_ir = ei; v.e_user = eu; v.e_abort = ea;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, then compare just after the edge.
  task automatic run_vec(input string tag, input vec_t v);
    vec_t e;
    {test_logic_reset, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr} = v.strb;
    tdi = v.tdi;
    user_capture_in = v.uin;
    exp_q.push_back(v);
    @(posedge tck);
    #1;
    e = exp_q.pop_front();
    check($sformatf("%s[%0d].tdo", tag, cyc), 32'(tdo), 32'(e.e_tdo));
    check($sformatf("%s[%0d].ir", tag, cyc), 32'(ir_value), 32'(e.e_ir));
    check($sformatf("%s[%0d].user_q", tag, cyc), 32'(user_q), 32'(e.e_user));
    check($sformatf("%s[%0d].abort", tag, cyc), 32'(abort_pulse), 32'(e.e_abort));
    cyc++;
  endtask

  initial begin
    logic [7:0] ucap;
    logic [7:0] uscan;
    ucap  = UCAP;
    uscan = USCAN;

    // IR to BYPASS, then BYPASS scan
    tbl.push_back(mk(S_CIR, 0, 8'h00, 0, 4'hE, 8'h00, 0));
    tbl.push_back(mk(S_SIR, 1, 8'h00, 1, 4'hE, 8'h00, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(S_SIR, 1, 8'h00, 0, 4'hE, 8'h00, 0));
    tbl.push_back(mk(S_UIR, 0, 8'h00, 0, 4'hF, 8'h00, 0));
    tbl.push_back(mk(S_CDR, 0, 8'h00, 0, 4'hF, 8'h00, 0));
    tbl.push_back(mk(S_SDR, 1, 8'h00, 0, 4'hF, 8'h00, 0));
    tbl.push_back(mk(S_SDR, 0, 8'h00, 1, 4'hF, 8'h00, 0));
    tbl.push_back(mk(S_SDR, 1, 8'h00, 0, 4'hF, 8'h00, 0));
    tbl.push_back(mk(S_SDR, 1, 8'h00, 1, 4'hF, 8'h00, 0));
    tbl.push_back(mk(S_NONE, 0, 8'h00, 0, 4'hF, 8'h00, 0));
    // IR to USER (0010 LSB first: 0,1,0,0)
    tbl.push_back(mk(S_CIR, 0, 8'h00, 0, 4'hF, 8'h00, 0));
    tbl.push_back(mk(S_SIR, 0, 8'h00, 1, 4'hF, 8'h00, 0));
    tbl.push_back(mk(S_SIR, 1, 8'h00, 0, 4'hF, 8'h00, 0));
    tbl.push_back(mk(S_SIR, 0, 8'h00, 0, 4'hF, 8'h00, 0));
    tbl.push_back(mk(S_SIR, 0, 8'h00, 0, 4'hF, 8'h00, 0));
    tbl.push_back(mk(S_UIR, 0, 8'h00, 0, 4'h2, 8'h00, 0));
    // USER capture A5, shift in 3C, update
    tbl.push_back(mk(S_CDR, 0, UCAP, 0, 4'h2, 8'h00, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(S_SDR, uscan[i], 8'h00, ucap[i], 4'h2, 8'h00, 0));
    tbl.push_back(mk(S_UDR, 0, 8'h00, 0, 4'h2, USCAN, 0));
    // Priority: capture beats shift, capture beats update
    tbl.push_back(mk(S_CDR | S_SDR, 1, 8'h81, 0, 4'h2, USCAN, 0));
    tbl.push_back(mk(S_SDR, 0, 8'h00, 1, 4'h2, USCAN, 0));
    tbl.push_back(mk(S_CDR | S_UDR, 0, 8'h01, 0, 4'h2, USCAN, 0));
    tbl.push_back(mk(S_SDR, 0, 8'h00, 1, 4'h2, USCAN, 0));
    // IR to ABORT (1000 LSB first: 0,0,0,1), one-cycle pulse
    tbl.push_back(mk(S_CIR, 0, 8'h00, 0, 4'h2, USCAN, 0));
    tbl.push_back(mk(S_SIR, 0, 8'h00, 1, 4'h2, USCAN, 0));
    tbl.push_back(mk(S_SIR, 0, 8'h00, 0, 4'h2, USCAN, 0));
    tbl.push_back(mk(S_SIR, 0, 8'h00, 0, 4'h2, USCAN, 0));
    tbl.push_back(mk(S_SIR, 1, 8'h00, 0, 4'h2, USCAN, 0));
    tbl.push_back(mk(S_UIR, 0, 8'h00, 0, 4'h8, USCAN, 1));
    tbl.push_back(mk(S_NONE, 0, 8'h00, 0, 4'h8, USCAN, 0));
    // ABORT has no DR capture: bypass bit still holds the 1 left by the BYPASS scan
    tbl.push_back(mk(S_CDR, 0, 8'h00, 0, 4'h8, USCAN, 0));
    tbl.push_back(mk(S_SDR, 0, 8'h00, 1, 4'h8, USCAN, 0));
    tbl.push_back(mk(S_SDR, 0, 8'h00, 0, 4'h8, USCAN, 0));
    tbl.push_back(mk(S_TLR, 0, 8'h00, 0, 4'hE, USCAN, 0));
    // Unknown code 0101 behaves as BYPASS
    tbl.push_back(mk(S_CIR, 0, 8'h00, 0, 4'hE, USCAN, 0));
    tbl.push_back(mk(S_SIR, 1, 8'h00, 1, 4'hE, USCAN, 0));
    tbl.push_back(mk(S_SIR, 0, 8'h00, 0, 4'hE, USCAN, 0));
    tbl.push_back(mk(S_SIR, 1, 8'h00, 0, 4'hE, USCAN, 0));
    tbl.push_back(mk(S_SIR, 0, 8'h00, 0, 4'hE, USCAN, 0));
    tbl.push_back(mk(S_UIR, 0, 8'h00, 0, 4'h5, USCAN, 0));
    tbl.push_back(mk(S_CDR, 0, 8'h00, 0, 4'h5, USCAN, 0));
    tbl.push_back(mk(S_SDR, 1, 8'h00, 0, 4'h5, USCAN, 0));
    tbl.push_back(mk(S_SDR, 0, 8'h00, 1, 4'h5, USCAN, 0));
    // Test-Logic-Reset beats shift
    tbl.push_back(mk(S_TLR | S_SIR, 1, 8'h00, 0, 4'hE, USCAN, 0));
    // Start an IR scan that the async reset will cut short
    tbl.push_back(mk(S_CIR, 0, 8'h00, 0, 4'hE, USCAN, 0));
    tbl.push_back(mk(S_SIR, 0, 8'h00, 1, 4'hE, USCAN, 0));

    trst = 1'b1;
    tdi = 1'b0;
    {test_logic_reset, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr} = S_NONE;
    user_capture_in = 8'h00;
    #12;
    check("reset.tdo", 32'(tdo), 32'h0);
    check("reset.ir", 32'(ir_value), 32'hE);
    check("reset.user_q", 32'(user_q), 32'h0);
    check("reset.abort", 32'(abort_pulse), 32'h0);
    #1 trst = 1'b0;
    @(posedge tck);
    #1;

    // IDCODE scan with tdi=0, then recapture and push PAT through to show wrap-through
    run_vec("idc_cap", mk(S_CDR, 0, 8'h00, 0, 4'hE, 8'h00, 0));
    for (int i = 0; i < 32; i++) run_vec("idc", mk(S_SDR, 0, 8'h00, IDC[i], 4'hE, 8'h00, 0));
    run_vec("idc_cap2", mk(S_CDR, 0, 8'h00, 0, 4'hE, 8'h00, 0));
    for (int i = 0; i < 32; i++) run_vec("idc2", mk(S_SDR, PAT[i], 8'h00, IDC[i], 4'hE, 8'h00, 0));
    for (int i = 0; i < 8; i++) run_vec("wrap", mk(S_SDR, 0, 8'h00, PAT[i], 4'hE, 8'h00, 0));
    run_vec("idle", mk(S_NONE, 0, 8'h00, 0, 4'hE, 8'h00, 0));

    for (int i = 0; i < tbl.size(); i++) run_vec("tbl", tbl[i]);

    // tdo is 1 here; trst pulse between edges must clear everything at once
    #2 trst = 1'b1;
    #1;
    check("async_rst.tdo", 32'(tdo), 32'h0);
    check("async_rst.ir", 32'(ir_value), 32'hE);
    check("async_rst.user_q", 32'(user_q), 32'h0);
    check("async_rst.abort", 32'(abort_pulse), 32'h0);
    #1 trst = 1'b0;
    @(posedge tck);
    #1;
    run_vec("post_rst_cap", mk(S_CDR, 0, 8'h00, 0, 4'hE, 8'h00, 0));
    run_vec("post_rst_sh", mk(S_SDR, 0, 8'h00, IDC[0], 4'hE, 8'h00, 0));

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
